tta_line_server: RTL and testbench

Parametrised, synthesizable instruction-line server for the TTA core's L1 refill port. It accepts a line fetch request, waits a configurable number of cycles, then streams LINE_WORDS words one per cycle from an internal line-organised RAM. It supports abort and optional critical-word-first ordering, and has a side write port for program loading. It replaces the fixed 16-word, zero-latency bench memory with a reusable block for simulation and FPGA builds.

---
 rtl/tta_line_server.sv | 170 +++++++++++++++++
 tb/tb_tta_line_server.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tta_line_server.sv
// tta_line_server
//
// Instruction-line server for the L1 refill port. A fetch latches a line
// index and word offset. After LATENCY wait cycles, LINE_WORDS words are
// streamed one per cycle from an internal line-organised RAM, either from
// word 0 or critical-word-first with wrap. A side port loads the RAM at any
// time. RAM contents are not touched by reset.
//
// Ports
//   clock_i    rising-edge clock
//   reset_i    synchronous active-high reset
//   ifetch_i   line request, only looked at in IDLE
//   iabort_i   cancel the current or pending request
//   iaddr_i    word address: [OFF_BITS-1:0] offset, next LINE_BITS line index
//   iready_o   idata_o valid this cycle
//   idata_o    burst word, 0 when not valid
//   ilast_o    final word of the burst
//   ibusy_o    request in flight
//   wr_en_i    load-port write strobe
//   wr_addr_i  load-port word address {line, offset}
//   wr_data_i  load-port data
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | no request; ifetch_i accepted unless iabort_i
// ST_WAIT  | request latched, counting down LATENCY cycles
// ST_BURST | one word read and registered to the output per cycle

module tta_line_server #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int ADDR_WIDTH  = 16,
   parameter  int LINE_WORDS  = 16,
   parameter  int DEPTH_LINES = 32,
   parameter  int LATENCY     = 0,
   parameter  int CWF         = 0,
   localparam int OFF_BITS    = $clog2(LINE_WORDS),
   localparam int LINE_BITS   = $clog2(DEPTH_LINES),
   localparam int WADDR_BITS  = OFF_BITS + LINE_BITS
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  ifetch_i,
   input  logic                  iabort_i,
   input  logic [ADDR_WIDTH-1:0] iaddr_i,
   output logic                  iready_o,
   output logic [DATA_WIDTH-1:0] idata_o,
   output logic                  ilast_o,
   output logic                  ibusy_o,
   input  logic                  wr_en_i,
   input  logic [WADDR_BITS-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i
);

   localparam int          LAT_M1    = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam int          MEM_WORDS = DEPTH_LINES * LINE_WORDS;
   localparam logic [3:0]  WAIT_LOAD = 4'(LAT_M1);
   localparam logic [OFF_BITS-1:0] LEFT_LOAD = OFF_BITS'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    load;
   logic                    emit;

   logic [LINE_BITS-1:0]    line_q;
   logic [OFF_BITS-1:0]     ptr_q;
   logic [OFF_BITS-1:0]     left_q;
   logic [3:0]              wait_q;

   logic                    iready_q;
   logic                    ilast_q;
   logic                    ibusy_q;
   logic [DATA_WIDTH-1:0]   idata_q;

   logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
   logic [WADDR_BITS-1:0]   rd_addr;

   // Bits above the line index alias; offset bits are unused when CWF=0.
   wire unused_iaddr = ^iaddr_i;

   // Pointer wraps naturally at OFF_BITS, giving the CWF modulo order.
   assign rd_addr = {line_q, ptr_q};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      emit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ifetch_i && !iabort_i) begin
               load    = 1'b1;
               state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (iabort_i) begin
               state_d = ST_IDLE;
            end else if (wait_q == 4'd0) begin
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (iabort_i) begin
               state_d = ST_IDLE;
            end else begin
               emit = 1'b1;
               if (left_q == '0) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         line_q   <= '0;
         ptr_q    <= '0;
         left_q   <= '0;
         wait_q   <= '0;
         iready_q <= 1'b0;
         ilast_q  <= 1'b0;
         ibusy_q  <= 1'b0;
         idata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            line_q <= iaddr_i[WADDR_BITS-1:OFF_BITS];
            ptr_q  <= (CWF != 0) ? iaddr_i[OFF_BITS-1:0] : '0;
            left_q <= LEFT_LOAD;
            wait_q <= WAIT_LOAD;
         end else begin
            if (state_q == ST_WAIT && wait_q != 4'd0) begin
               wait_q <= wait_q - 4'd1;
            end
            if (emit) begin
               ptr_q  <= ptr_q + 1'b1;
               left_q <= left_q - 1'b1;
            end
         end
         iready_q <= emit;
         ilast_q  <= emit && (left_q == '0);
         // Busy covers the final word cycle even though the FSM is
         // already back in IDLE while that word is on the output.
         ibusy_q  <= (state_d != ST_IDLE) || emit;
         // Same-edge read and write: the nonblocking write below lands
         // after this read, so the old word is returned.
         idata_q  <= emit ? mem[rd_addr] : '0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   assign iready_o = iready_q;
   assign ilast_o  = ilast_q;
   assign ibusy_o  = ibusy_q;
   assign idata_o  = idata_q;

endmodule

// File: tb/tb_tta_line_server.sv
// Bench for tta_line_server: three instances (defaults; CWF=1 with
// LATENCY=3; LINE_WORDS=4 with DEPTH_LINES=8), directed stimulus with
// hand-computed expected words. Inputs change 1 ns after the rising edge
// and outputs are sampled there too.

module tb_tta_line_server;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifetch, ifetch2, iabort;
   logic [15:0] iaddr;
   logic        wr_en, wr_en2;
   logic [8:0]  wr_addr;
   logic [4:0]  wr_addr2;
   logic [31:0] wr_data;

   logic        r0, l0, b0, r1, l1, b1, r2, l2, b2;
   logic [31:0] d0, d1, d2;

   int total  = 0;
   int passed = 0;

   always #5 clock = ~clock;

   tta_line_server dut0 (
      .clock_i(clock), .reset_i(reset), .ifetch_i(ifetch), .iabort_i(iabort),
      .iaddr_i(iaddr), .iready_o(r0), .idata_o(d0), .ilast_o(l0), .ibusy_o(b0),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
   );

   tta_line_server #(.LATENCY(3), .CWF(1)) dut1 (
      .clock_i(clock), .reset_i(reset), .ifetch_i(ifetch), .iabort_i(iabort),
      .iaddr_i(iaddr), .iready_o(r1), .idata_o(d1), .ilast_o(l1), .ibusy_o(b1),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
   );

   tta_line_server #(.LINE_WORDS(4), .DEPTH_LINES(8)) dut2 (
      .clock_i(clock), .reset_i(reset), .ifetch_i(ifetch2), .iabort_i(iabort),
      .iaddr_i(iaddr), .iready_o(r2), .idata_o(d2), .ilast_o(l2), .ibusy_o(b2),
      .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ifetch = 1'b0; ifetch2 = 1'b0; iabort = 1'b0;
      iaddr = '0; wr_en = 1'b0; wr_en2 = 1'b0; wr_addr = '0; wr_addr2 = '0;
      wr_data = '0;
      tick(); tick();
      total++;
      if ({r0, l0, b0, d0} !== 35'h0)
         $display("FAIL reset_dut0: got r=%b l=%b b=%b d=%h, expected all 0", r0, l0, b0, d0);
      else passed++;
      total++;
      if ({r1, l1, b1, r2, l2, b2} !== 6'b0)
         $display("FAIL reset_others: got %b, expected 000000", {r1, l1, b1, r2, l2, b2});
      else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic load_ram();
      for (int i = 0; i < 512; i++) begin
         wr_en = 1'b1; wr_addr = 9'(i); wr_data = 32'(i);
         wr_en2 = (i < 32); wr_addr2 = 5'(i);
         tick();
      end
      wr_en = 1'b0; wr_en2 = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      iaddr = 16'h0025; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      total++;
      if ({r0, b0} !== 2'b01)
         $display("FAIL basic_lat: got r=%b b=%b, expected r=0 b=1", r0, b0);
      else passed++;
      tick();
      for (int i = 0; i < 16; i++) begin
         total++;
         if ({r0, l0, b0, d0} !== {1'b1, (i == 15), 1'b1, 32'(32'h20 + i)})
            $display("FAIL basic_word%0d: got r=%b l=%b b=%b d=%h, expected r=1 l=%b b=1 d=%h",
                     i, r0, l0, b0, d0, (i == 15), 32'h20 + i);
         else passed++;
         tick();
      end
      total++;
      if ({r0, l0, b0} !== 3'b000)
         $display("FAIL basic_end: got r=%b l=%b b=%b, expected 000", r0, l0, b0);
      else passed++;
      repeat (25) tick();
   endtask

   task automatic test_cwf();
      iaddr = 16'h0025; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      for (int j = 0; j < 4; j++) begin
         total++;
         if ({r1, b1} !== 2'b01)
            $display("FAIL cwf_wait%0d: got r=%b b=%b, expected r=0 b=1", j, r1, b1);
         else passed++;
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if ({r1, l1, d1} !== {1'b1, (i == 15), 32'(32'h20 + ((5 + i) % 16))})
            $display("FAIL cwf_word%0d: got r=%b l=%b d=%h, expected r=1 l=%b d=%h",
                     i, r1, l1, d1, (i == 15), 32'h20 + ((5 + i) % 16));
         else passed++;
         tick();
      end
      total++;
      if ({r1, b1} !== 2'b00)
         $display("FAIL cwf_end: got r=%b b=%b, expected 00", r1, b1);
      else passed++;
      repeat (25) tick();
   endtask

   task automatic test_abort();
      iaddr = 16'h0020; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({r0, d0} !== {1'b1, 32'(32'h20 + i)})
            $display("FAIL abort_word%0d: got r=%b d=%h, expected r=1 d=%h", i, r0, d0, 32'h20 + i);
         else passed++;
         if (i < 3) tick();
      end
      iabort = 1'b1;
      tick();
      iabort = 1'b0;
      total++;
      if ({r0, l0, b0} !== 3'b000)
         $display("FAIL abort_stop: got r=%b l=%b b=%b, expected 000", r0, l0, b0);
      else passed++;
      tick();
      total++;
      if ({r0, b0} !== 2'b00)
         $display("FAIL abort_idle: got r=%b b=%b, expected 00", r0, b0);
      else passed++;
      iaddr = 16'h0070; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      tick();
      total++;
      if ({r0, d0} !== {1'b1, 32'h70})
         $display("FAIL abort_refetch: got r=%b d=%h, expected r=1 d=00000070", r0, d0);
      else passed++;
      repeat (25) tick();
   endtask

   task automatic test_abort_fetch_idle();
      int hits;
      hits = 0;
      iaddr = 16'h0040; ifetch = 1'b1; iabort = 1'b1;
      tick();
      ifetch = 1'b0; iabort = 1'b0;
      repeat (20) begin
         if (r0 || b0) hits++;
         tick();
      end
      total++;
      if (hits !== 0)
         $display("FAIL abort_and_fetch: got %0d active cycles, expected 0", hits);
      else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_r, exp_l;
      int   w;
      iaddr = 16'h0030; ifetch = 1'b1;
      for (int t = 0; t <= 34; t++) begin
         tick();
         exp_r = (t >= 1 && t <= 16) || (t >= 18 && t <= 33);
         exp_l = (t == 16) || (t == 33);
         w     = (t <= 16) ? t - 1 : t - 18;
         total++;
         if (exp_r) begin
            if ({r0, l0, d0} !== {1'b1, exp_l, 32'(32'h30 + w)})
               $display("FAIL b2b_t%0d: got r=%b l=%b d=%h, expected r=1 l=%b d=%h",
                        t, r0, l0, d0, exp_l, 32'h30 + w);
            else passed++;
         end else begin
            if ({r0, l0} !== 2'b00)
               $display("FAIL b2b_t%0d: got r=%b l=%b, expected r=0 l=0", t, r0, l0);
            else passed++;
         end
         if (t == 17) begin
            total++;
            if (b0 !== 1'b1)
               $display("FAIL b2b_gap_busy: got b=%b, expected 1", b0);
            else passed++;
            ifetch = 1'b0;
         end
      end
      repeat (25) tick();
   endtask

   task automatic test_reset_midburst();
      int hits;
      hits = 0;
      iaddr = 16'h0020; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      tick();
      total++;
      if ({r0, d0} !== {1'b1, 32'h20})
         $display("FAIL rst_word0: got r=%b d=%h, expected r=1 d=00000020", r0, d0);
      else passed++;
      wr_en = 1'b1; wr_addr = 9'h021; wr_data = 32'hDEAD;
      tick();
      wr_en = 1'b0;
      total++;
      if ({r0, d0} !== {1'b1, 32'h21})
         $display("FAIL rst_read_first: got r=%b d=%h, expected r=1 d=00000021", r0, d0);
      else passed++;
      repeat (7) tick();
      total++;
      if ({r0, d0} !== {1'b1, 32'h28})
         $display("FAIL rst_word8: got r=%b d=%h, expected r=1 d=00000028", r0, d0);
      else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({r0, l0, b0, d0} !== 35'h0)
         $display("FAIL rst_outputs: got r=%b l=%b b=%b d=%h, expected all 0", r0, l0, b0, d0);
      else passed++;
      repeat (20) begin
         if (r0 || l0 || b0) hits++;
         tick();
      end
      total++;
      if (hits !== 0)
         $display("FAIL rst_quiet: got %0d active cycles, expected 0", hits);
      else passed++;
      iaddr = 16'h0020; ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
      tick();
      total++;
      if ({r0, d0} !== {1'b1, 32'h20})
         $display("FAIL rst_refetch0: got r=%b d=%h, expected r=1 d=00000020", r0, d0);
      else passed++;
      tick();
      total++;
      if ({r0, d0} !== {1'b1, 32'hDEAD})
         $display("FAIL rst_refetch1: got r=%b d=%h, expected r=1 d=0000dead", r0, d0);
      else passed++;
      repeat (25) tick();
   endtask

   task automatic test_alias();
      // 0xFFF3 with 2 offset bits and 3 line bits: line 4, offset 3.
      iaddr = 16'hFFF3; ifetch2 = 1'b1;
      tick();
      ifetch2 = 1'b0;
      total++;
      if ({r2, b2} !== 2'b01)
         $display("FAIL alias_lat: got r=%b b=%b, expected r=0 b=1", r2, b2);
      else passed++;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({r2, l2, d2} !== {1'b1, (i == 3), 32'(32'h10 + i)})
            $display("FAIL alias_word%0d: got r=%b l=%b d=%h, expected r=1 l=%b d=%h",
                     i, r2, l2, d2, (i == 3), 32'h10 + i);
         else passed++;
         tick();
      end
      total++;
      if ({r2, b2} !== 2'b00)
         $display("FAIL alias_end: got r=%b b=%b, expected 00", r2, b2);
      else passed++;
      repeat (5) tick();
   endtask

   initial begin
      test_reset();
      load_ram();
      test_basic();
      test_cwf();
      test_abort();
      test_abort_fetch_idle();
      test_back_to_back();
      test_reset_midburst();
      test_alias();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
